// File: rtl/irq_iack.sv
// 68000 interrupt controller: synchronises and priority-encodes IRQ lines onto IPL,
// then answers each IACK bus cycle with autovector, a vectoring-device strobe, or bus error.
module irq_iack #(
    parameter logic [6:0] VECTORED_MASK = 7'b0001000,
    parameter int         TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] irq_n,
    input  logic       as_n,
    input  logic [2:0] fc,
    input  logic [3:0] a_hi,
    input  logic [2:0] a_lvl,
    input  logic       dtack_n,
    output logic [2:0] ipl_n,
    output logic       vpa_n,
    output logic       berr_n,
    output logic [6:0] iack_n,
    output logic       iack_active
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK_VEC,
        S_ACK_AUTO,
        S_SPUR,
        S_FAULT,
        S_HOLD
    } state_t;

    // Highest asserted (active-low) request level, 0 when nothing is pending.
    function automatic logic [2:0] f_prio(input logic [6:0] req_n);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!req_n[i]) lvl = 3'(i + 1);
        end
        return lvl;
    endfunction

    logic [6:0] r_irq_p0;
    logic [6:0] r_req_p1;
    logic [2:0] r_ipl_n;
    logic       r_as_n;
    logic       r_dtack_n;
    logic [2:0] r_fc;
    logic [3:0] r_a_hi;
    logic [2:0] r_a_lvl;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_vpa_n;
    logic       r_berr_n;
    logic [6:0] r_iack_n;
    logic       r_active;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_vpa_nxt;
    logic       w_berr_nxt;
    logic [6:0] w_iack_nxt;
    logic       w_active_nxt;

    logic       w_dec;
    logic [6:0] w_lvl_oh;
    logic       w_lvl_req;
    logic       w_lvl_vec;

    // Stage p0/p1: two-flop request synchroniser; p2: registered priority level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_p0  <= 7'h7F;
            r_req_p1  <= 7'h7F;
            r_ipl_n   <= 3'b111;
            r_as_n    <= 1'b1;
            r_dtack_n <= 1'b1;
        end else begin
            r_irq_p0  <= irq_n;
            r_req_p1  <= r_irq_p0;
            r_ipl_n   <= ~f_prio(r_req_p1);
            r_as_n    <= as_n;
            r_dtack_n <= dtack_n;
        end
    end

    always_ff @(posedge clk) begin
        r_fc    <= fc;
        r_a_hi  <= a_hi;
        r_a_lvl <= a_lvl;
    end

    assign w_dec     = !r_as_n && (r_fc == 3'b111) && (r_a_hi == 4'hF) && (r_a_lvl != 3'd0);
    assign w_lvl_oh  = 7'd1 << (r_a_lvl - 3'd1);
    assign w_lvl_req = |(~r_req_p1 & w_lvl_oh);
    assign w_lvl_vec = |(VECTORED_MASK & w_lvl_oh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_vpa_n  <= 1'b1;
            r_berr_n <= 1'b1;
            r_iack_n <= 7'h7F;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vpa_n  <= w_vpa_nxt;
            r_berr_n <= w_berr_nxt;
            r_iack_n <= w_iack_nxt;
            r_active <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_vpa_nxt    = r_vpa_n;
        w_berr_nxt   = r_berr_n;
        w_iack_nxt   = r_iack_n;
        w_active_nxt = r_active;

        if (r_state == S_IDLE) begin
            if (w_dec) begin
                w_cnt_nxt    = 8'd0;
                w_active_nxt = 1'b1;
                if (!w_lvl_req) begin
                    w_state_nxt = S_SPUR;
                end else if (w_lvl_vec) begin
                    w_state_nxt = S_ACK_VEC;
                    w_iack_nxt  = ~w_lvl_oh;
                end else begin
                    w_state_nxt = S_ACK_AUTO;
                    w_vpa_nxt   = 1'b0;
                end
            end
        end else if (r_as_n) begin
            // CPU ended (or aborted) the cycle: drop every strobe together.
            w_state_nxt  = S_IDLE;
            w_vpa_nxt    = 1'b1;
            w_berr_nxt   = 1'b1;
            w_iack_nxt   = 7'h7F;
            w_active_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ACK_VEC: begin
                    if (!r_dtack_n) begin
                        w_state_nxt = S_HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_FAULT;
                        w_iack_nxt  = 7'h7F;
                        w_berr_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_ACK_AUTO: w_state_nxt = S_HOLD;
                S_SPUR: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_FAULT;
                        w_berr_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_FAULT: w_state_nxt = S_HOLD;
                S_HOLD:  w_state_nxt = S_HOLD;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign ipl_n       = r_ipl_n;
    assign vpa_n       = r_vpa_n;
    assign berr_n      = r_berr_n;
    assign iack_n      = r_iack_n;
    assign iack_active = r_active;

endmodule

// File: tb/tb_irq_iack.sv
// Bench for irq_iack: directed stimulus schedules expected outputs into a
// scoreboard keyed by clock count; a negedge monitor compares them as they fall due.
module tb_irq_iack;

    localparam int TIMEOUT = 16;

    localparam int SIG_IPL  = 0;
    localparam int SIG_VPA  = 1;
    localparam int SIG_BERR = 2;
    localparam int SIG_IACK = 3;
    localparam int SIG_ACT  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] irq_n;
    logic       as_n;
    logic [2:0] fc;
    logic [3:0] a_hi;
    logic [2:0] a_lvl;
    logic       dtack_n;
    logic [2:0] ipl_n;
    logic       vpa_n;
    logic       berr_n;
    logic [6:0] iack_n;
    logic       iack_active;

    irq_iack #(.VECTORED_MASK(7'b0001000), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_n      (irq_n),
        .as_n       (as_n),
        .fc         (fc),
        .a_hi       (a_hi),
        .a_lvl      (a_lvl),
        .dtack_n    (dtack_n),
        .ipl_n      (ipl_n),
        .vpa_n      (vpa_n),
        .berr_n     (berr_n),
        .iack_n     (iack_n),
        .iack_active(iack_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         sig;
        logic [6:0] exp;
        int         due;
    } chk_t;

    chk_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [6:0] sample(input int s);
        case (s)
            SIG_IPL:  return {4'b0, ipl_n};
            SIG_VPA:  return {6'b0, vpa_n};
            SIG_BERR: return {6'b0, berr_n};
            SIG_IACK: return iack_n;
            default:  return {6'b0, iack_active};
        endcase
    endfunction

    task automatic expect_at(input string nm, input int s, input logic [6:0] v, input int d);
        chk_t c;
        c.name = nm;
        c.sig  = s;
        c.exp  = v;
        c.due  = cyc + d;
        sb.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_iack(input logic [2:0] lvl);
        as_n  = 1'b0;
        fc    = 3'b111;
        a_hi  = 4'hF;
        a_lvl = lvl;
    endtask

    task automatic end_cycle();
        as_n    = 1'b1;
        fc      = 3'b000;
        a_hi    = 4'h0;
        a_lvl   = 3'd0;
        dtack_n = 1'b1;
    endtask

    // Monitor: compares every scheduled expectation whose clock has arrived.
    always @(negedge clk) begin
        int i;
        logic [6:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                got = sample(sb[i].sig);
                n_vec++;
                if (got !== sb[i].exp) begin
                    n_miss++;
                    $display("FAIL %s @cyc %0d: got %b, want %b", sb[i].name, cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: expectation for cyc %0d never sampled", sb[i].name, sb[i].due);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        reset   = 1'b1;
        irq_n   = 7'h7F;
        end_cycle();

        tick(1);
        expect_at("rst_ipl",  SIG_IPL,  7'b111,     0);
        expect_at("rst_vpa",  SIG_VPA,  7'd1,       0);
        expect_at("rst_berr", SIG_BERR, 7'd1,       0);
        expect_at("rst_iack", SIG_IACK, 7'h7F,      0);
        expect_at("rst_act",  SIG_ACT,  7'd0,       0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Priority and 3-clock latency
        irq_n = 7'b1111011;
        expect_at("prio_l3_early", SIG_IPL, 7'b111, 2);
        expect_at("prio_l3",       SIG_IPL, 7'b100, 3);
        tick(4);
        irq_n = 7'b1011011;
        expect_at("prio_l6_early", SIG_IPL, 7'b100, 2);
        expect_at("prio_l6",       SIG_IPL, 7'b001, 3);
        tick(4);
        irq_n = 7'b1111011;
        expect_at("prio_back_l3", SIG_IPL, 7'b100, 3);
        tick(4);

        // Autovector on level 3
        start_iack(3'd3);
        expect_at("auto_vpa_early", SIG_VPA,  7'd1,  1);
        expect_at("auto_vpa",       SIG_VPA,  7'd0,  2);
        expect_at("auto_act",       SIG_ACT,  7'd1,  2);
        expect_at("auto_iack",      SIG_IACK, 7'h7F, 2);
        expect_at("auto_berr",      SIG_BERR, 7'd1,  2);
        tick(5);
        expect_at("auto_vpa_hold",  SIG_VPA,  7'd0,   0);
        expect_at("auto_ipl_live",  SIG_IPL,  7'b100, 0);
        end_cycle();
        expect_at("auto_vpa_tail",  SIG_VPA,  7'd0,  1);
        expect_at("auto_vpa_rel",   SIG_VPA,  7'd1,  2);
        expect_at("auto_act_rel",   SIG_ACT,  7'd0,  2);
        tick(3);

        // Vectored DUART on level 4, answered by DTACK
        irq_n = 7'b1110111;
        tick(4);
        start_iack(3'd4);
        expect_at("vec_iack_early", SIG_IACK, 7'h7F,      1);
        expect_at("vec_iack",       SIG_IACK, 7'b1110111, 2);
        expect_at("vec_vpa",        SIG_VPA,  7'd1,       2);
        expect_at("vec_act",        SIG_ACT,  7'd1,       2);
        tick(3);
        dtack_n = 1'b0;
        tick(3);
        expect_at("vec_iack_hold",  SIG_IACK, 7'b1110111, 0);
        expect_at("vec_berr_hold",  SIG_BERR, 7'd1,       0);
        expect_at("vec_vpa_hold",   SIG_VPA,  7'd1,       0);
        end_cycle();
        expect_at("vec_iack_tail",  SIG_IACK, 7'b1110111, 1);
        expect_at("vec_iack_rel",   SIG_IACK, 7'h7F,      2);
        expect_at("vec_act_rel",    SIG_ACT,  7'd0,       2);
        tick(3);

        // Vectored level 4 with no DTACK: timeout to bus error
        start_iack(3'd4);
        expect_at("to_iack_last",  SIG_IACK, 7'b1110111, TIMEOUT + 1);
        expect_at("to_berr_early", SIG_BERR, 7'd1,       TIMEOUT + 1);
        expect_at("to_berr",       SIG_BERR, 7'd0,       TIMEOUT + 2);
        expect_at("to_iack_rel",   SIG_IACK, 7'h7F,      TIMEOUT + 2);
        expect_at("to_act",        SIG_ACT,  7'd1,       TIMEOUT + 2);
        tick(TIMEOUT + 6);
        expect_at("to_berr_hold",  SIG_BERR, 7'd0, 0);
        end_cycle();
        expect_at("to_berr_tail",  SIG_BERR, 7'd0, 1);
        expect_at("to_berr_rel",   SIG_BERR, 7'd1, 2);
        expect_at("to_act_rel",    SIG_ACT,  7'd0, 2);
        tick(3);

        // Spurious: nothing pending, level 5 acknowledged
        irq_n = 7'h7F;
        tick(4);
        start_iack(3'd5);
        expect_at("sp_act",        SIG_ACT,  7'd1,  2);
        expect_at("sp_vpa",        SIG_VPA,  7'd1,  2);
        expect_at("sp_iack",       SIG_IACK, 7'h7F, 2);
        expect_at("sp_vpa_mid",    SIG_VPA,  7'd1,  10);
        expect_at("sp_iack_mid",   SIG_IACK, 7'h7F, 10);
        expect_at("sp_berr_early", SIG_BERR, 7'd1,  TIMEOUT + 1);
        expect_at("sp_berr",       SIG_BERR, 7'd0,  TIMEOUT + 2);
        expect_at("sp_iack_late",  SIG_IACK, 7'h7F, TIMEOUT + 2);
        tick(TIMEOUT + 3);
        end_cycle();
        expect_at("sp_berr_tail",  SIG_BERR, 7'd0, 1);
        expect_at("sp_berr_rel",   SIG_BERR, 7'd1, 2);
        tick(3);

        // Non-IACK cycles are ignored
        irq_n = 7'b1111011;
        tick(4);
        as_n  = 1'b0;
        fc    = 3'b101;
        a_hi  = 4'hF;
        a_lvl = 3'd3;
        expect_at("nonack_act", SIG_ACT, 7'd0, 2);
        expect_at("nonack_vpa", SIG_VPA, 7'd1, 4);
        tick(4);
        end_cycle();
        tick(2);
        start_iack(3'd0);
        expect_at("cpusp_act", SIG_ACT, 7'd0, 2);
        expect_at("cpusp_vpa", SIG_VPA, 7'd1, 4);
        tick(4);
        end_cycle();
        tick(2);

        // Reset asserted mid-autovector: outputs release before the next edge
        start_iack(3'd3);
        expect_at("rmid_vpa_set", SIG_VPA, 7'd0, 2);
        tick(3);
        reset = 1'b1;
        irq_n = 7'h7F;
        end_cycle();
        expect_at("rmid_vpa",  SIG_VPA,  7'd1,   0);
        expect_at("rmid_ipl",  SIG_IPL,  7'b111, 0);
        expect_at("rmid_iack", SIG_IACK, 7'h7F,  0);
        expect_at("rmid_act",  SIG_ACT,  7'd0,   0);
        tick(2);
        reset = 1'b0;
        expect_at("post_ipl",  SIG_IPL,  7'b111, 4);
        expect_at("post_vpa",  SIG_VPA,  7'd1,   4);
        expect_at("post_berr", SIG_BERR, 7'd1,   4);
        expect_at("post_act",  SIG_ACT,  7'd0,   4);
        tick(6);

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
